// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor bus constants and responder state type
// Purpose: vector addresses used by proc and its bus targets, the bus
//          responder state encoding, and the vector-byte selector.
// Ports:   none (package).
package proc_pkg;

  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;

  // One-hot so a corrupted state is easy to spot and decode stays trivial.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_LAST = 3'b100
  } resp_state_e;

  // Byte returned for one of the four vector addresses FFFC..FFFF,
  // selected by the low two address bits (little-endian vectors).
  function automatic logic [7:0] vector_byte(input logic [1:0]  lsb,
                                             input logic [15:0] reset_pc,
                                             input logic [15:0] irq_pc);
    logic [7:0] b;
    case (lsb)
      2'd0:    b = reset_pc[7:0];
      2'd1:    b = reset_pc[15:8];
      2'd2:    b = irq_pc[7:0];
      default: b = irq_pc[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// rtl/bus_responder_if.sv - processor external bus between proc and a responder
// Purpose: bundles the address/data/handshake wires of the processor bus.
// Ports:   AB (address), RW (1=read), DB_OUT (write data from proc),
//          DB_IN (read data to proc), RDY (1=wait), SEL (target decoded).
//          master = processor side, slave = responder side.
interface bus_responder_if;

  logic [15:0] AB;
  logic        RW;
  logic [7:0]  DB_OUT;
  logic [7:0]  DB_IN;
  logic        RDY;
  logic        SEL;

  modport master (
    output AB, RW, DB_OUT,
    input  DB_IN, RDY, SEL
  );

  modport slave (
    input  AB, RW, DB_OUT,
    output DB_IN, RDY, SEL
  );

endinterface

// File: rtl/resp_ram.sv
// rtl/resp_ram.sv - byte RAM behind the bus responder
// Purpose: 2**ADDR_BITS x 8 storage, asynchronous read, synchronous write.
//          No reset: contents are undefined after power-up.
// Ports:   clk, we (write enable), addr, wdata, rdata (combinational).
module resp_ram #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - memory-side target for the processor external bus
// Purpose: decodes AB/RW, serves reads/writes from a RAM window, returns the
//          reset/IRQ vectors from constants and stretches each access by
//          WAIT_STATES cycles through RDY.
// Ports:   clk  - system clock, rising edge
//          RES  - asynchronous active-low reset
//          bus  - slave side of bus_responder_if (AB, RW, DB_OUT in;
//                 DB_IN, RDY, SEL out)
module bus_responder
  import proc_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] RESET_PC    = 16'h0200,
  parameter logic [15:0] IRQ_PC      = 16'h0300
) (
  input  logic           clk,
  input  logic           RES,
  bus_responder_if.slave bus
);

  localparam bit ZERO_WAIT = (WAIT_STATES == 0);
  // The start cycle itself is the first wait cycle, so the counter only has
  // to cover the remaining W-1 cycles spent in ST_WAIT.
  localparam logic [3:0] CNT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam bit SKIP_WAIT = (WAIT_STATES <= 1);

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] lat_ab_q;
  logic        lat_rw_q;
  logic [7:0]  db_hold_q;

  logic        hit_ram, hit_vec, sel;
  logic        changed;
  logic        start, complete;
  logic        rdy_c;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  read_byte;
  logic [7:0]  db_in_c;

  assign hit_ram = (bus.AB[15:ADDR_BITS] == ADDR_BASE[15:ADDR_BITS]);
  assign hit_vec = (bus.AB >= RESET_VECTOR);
  assign sel     = hit_ram | hit_vec;

  // The processor holds AB/RW while stalled, so any change against the
  // latched access means it abandoned that access and started another.
  assign changed = (bus.AB != lat_ab_q) || (bus.RW != lat_rw_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start    = 1'b0;
    complete = 1'b0;

    if (!sel) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: start = 1'b1;
        ST_WAIT: begin
          if (changed) begin
            start = 1'b1;
          end else begin
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : 4'(cnt_q - 4'd1);
            state_d = (cnt_q <= 4'd1) ? ST_LAST : ST_WAIT;
          end
        end
        ST_LAST: begin
          // With zero wait states LAST is the post-completion state and every
          // selected cycle is a fresh access; otherwise LAST is the
          // completion cycle of the latched access.
          if (ZERO_WAIT || changed) begin
            start = 1'b1;
          end else begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (start) begin
        cnt_d   = CNT_LOAD;
        state_d = SKIP_WAIT ? ST_LAST : ST_WAIT;
        if (ZERO_WAIT) begin
          complete = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdy_c = 1'b0;
    if (sel) begin
      if (start) begin
        rdy_c = !ZERO_WAIT;
      end else begin
        rdy_c = (state_q == ST_WAIT);
      end
    end
  end

  assign read_byte = hit_vec ? vector_byte(bus.AB[1:0], RESET_PC, IRQ_PC)
                             : ram_rdata;

  always_comb begin
    db_in_c = db_hold_q;
    if (!sel) begin
      db_in_c = 8'hFF;
    end else if (complete && bus.RW) begin
      db_in_c = read_byte;
    end
  end

  // Reset forces the outputs combinationally so they drop the moment RES
  // falls, not at the next edge.
  assign bus.RDY   = RES & rdy_c;
  assign bus.DB_IN = RES ? db_in_c : 8'hFF;
  assign bus.SEL   = sel;

  // Vector addresses are read-only even when the RAM window overlaps them.
  assign ram_we = RES & complete & ~bus.RW & hit_ram & ~hit_vec;

  resp_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (bus.AB[ADDR_BITS-1:0]),
    .wdata (bus.DB_OUT),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge RES) begin
    if (!RES) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      lat_ab_q  <= 16'h0000;
      lat_rw_q  <= 1'b0;
      db_hold_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_hold_q <= db_in_c;
      if (start) begin
        lat_ab_q <= bus.AB;
        lat_rw_q <= bus.RW;
      end
    end
  end

endmodule
